// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// latched request record and word/wait-state limits.
package dmem_pkg;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_WAIT_STATES = 15;
  localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_WAIT = 2'd1;
  localparam logic [1:0] STATE_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    WAIT = STATE_WAIT,
    RESP = STATE_RESP
  } dmem_state_e;

  typedef struct packed {
    logic                    we;
    logic [31:0]             addr;
    logic [31:0]             wdata;
    logic [WORD_BYTES-1:0]   be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core (master)
// and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and registered read,
// split into one array per byte lane so each lane maps onto a block RAM.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [AW-1:0]         idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      // Read-before-write: a store returns the old lane contents, never used.
      always_ff @(posedge clk) begin
        if (en) begin
          if (we && be[gi]) begin
            mem[idx] <= wdata[8*gi +: 8];
          end
          rd_q <= mem[idx];
        end
      end

      assign rdata[8*gi +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states.
// Define DMEM_ERR_CHECK_EN to fault misaligned and out-of-window addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             srst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  dmem_req_t             req_q, req_d;
  logic                  err_q, err_d;

  dmem_req_t   live_req;
  dmem_req_t   acc_req;
  logic        accept;
  logic        acc_en;
  logic        acc_fault;
  logic [31:0] acc_off;
  logic [AW-1:0] acc_idx;
  logic [31:0] ram_rdata;

  assign live_req = '{we: bus.req_we, addr: bus.req_addr,
                      wdata: bus.req_wdata, be: bus.req_be};

  assign bus.req_ready = (state_q == IDLE) && srst;
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero wait states the access happens on the accepting edge, so the
  // live request fields feed the RAM instead of the not-yet-latched copy.
  assign acc_req = (state_q == IDLE) ? live_req : req_q;
  assign acc_en  = srst &&
                   (((state_q == IDLE) && accept && (WAIT_STATES == 0)) ||
                    ((state_q == WAIT) && (wait_cnt_q == WAIT_CNT_W'(1))));

  assign acc_off = acc_req.addr - BASE_ADDR;
  assign acc_idx = acc_off[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
  // BASE_ADDR is window-aligned, so any set bit above the index is out of range.
  assign acc_fault = (acc_off[1:0] != 2'b00) || (acc_off[31:AW+2] != '0);
`else
  logic unused_addr_bits;
  assign acc_fault        = 1'b0;
  assign unused_addr_bits = ^{acc_off[31:AW+2], acc_off[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d      = live_req;
          wait_cnt_d = WAIT_CNT_W'(WAIT_STATES);
          state_d    = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        if (wait_cnt_q == WAIT_CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (acc_en) begin
      err_d = acc_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      req_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      err_q      <= err_d;
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (acc_en && !acc_fault),
    .we    (acc_req.we),
    .be    (acc_req.be),
    .idx   (acc_idx),
    .wdata (acc_req.wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register holds the load data until the next access,
  // which cannot occur before the response handshake.
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = ((state_q == RESP) && !req_q.we && !err_q) ? ram_rdata : '0;

`ifdef DMEM_ERR_CHECK_EN
  assign bus.rsp_err = (state_q == RESP) && err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT with no wait states and one
// with three, each driven through its own interface instance.
module tb_dmem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst      [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_we    = req_we[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.req_wdata = req_wdata[0];
  assign bus0.req_be    = req_be[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign req_ready[0]   = bus0.req_ready;
  assign rsp_valid[0]   = bus0.rsp_valid;
  assign rsp_rdata[0]   = bus0.rsp_rdata;
  assign rsp_err[0]     = bus0.rsp_err;

  assign bus1.req_valid = req_valid[1];
  assign bus1.req_we    = req_we[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.req_wdata = req_wdata[1];
  assign bus1.req_be    = req_be[1];
  assign bus1.rsp_ready = rsp_ready[1];
  assign req_ready[1]   = bus1.req_ready;
  assign rsp_valid[1]   = bus1.rsp_valid;
  assign rsp_rdata[1]   = bus1.rsp_rdata;
  assign rsp_err[1]     = bus1.rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut0 (
    .clk  (clk),
    .srst (srst[0]),
    .bus  (bus0)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut3 (
    .clk  (clk),
    .srst (srst[1]),
    .bus  (bus1)
  );

  // Issue one request with rsp_ready held high; lat counts negedges from the
  // accepting edge until rsp_valid is seen (1 means next cycle).
  task automatic run_req(input int sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    rdata = '0;
    err   = 1'b0;
    @(negedge clk);
    req_we[sel]    = we;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    req_be[sel]    = be;
    req_valid[sel] = 1'b1;
    rsp_ready[sel] = 1'b1;
    guard = 0;
    while (!req_ready[sel] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid[sel] = 1'b0;
    lat = 1;
    while (!rsp_valid[sel] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[sel]) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout dut%0d addr=%h: no rsp_valid within %0d cycles", sel, addr, lat);
    end
    rdata = rsp_rdata[sel];
    err   = rsp_err[sel];
    @(negedge clk);
    rsp_ready[sel] = 1'b0;
    $display("xact dut%0d we=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
             sel, we, addr, wdata, be, rdata, err, lat);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      srst[s] = 1'b0; req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0; req_be[s] = '0; rsp_ready[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (req_ready[s] !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready dut%0d got=%b exp=0", s, req_ready[s]); end
      n_checks++;
      if (rsp_valid[s] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid dut%0d got=%b exp=0", s, rsp_valid[s]); end
      n_checks++;
      if (rsp_rdata[s] !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata dut%0d got=%h exp=0", s, rsp_rdata[s]); end
      n_checks++;
      if (rsp_err[s] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err dut%0d got=%b exp=0", s, rsp_err[s]); end
    end
    srst[0] = 1'b1;
    srst[1] = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (req_ready[s] !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready dut%0d got=%b exp=1", s, req_ready[s]); end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    run_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL ws0_store_latency got=%0d exp=1", lat); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL ws0_store_rdata got=%h exp=00000000", rd); end
    run_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL ws0_load_latency got=%0d exp=1", lat); end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ws0_load_rdata got=%h exp=deadbeef", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL ws0_load_err got=%b exp=0", er); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic er; int lat;
    run_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    run_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    run_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
    run_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    run_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_zero_noop got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    run_req(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL ws3_store_latency got=%0d exp=4", lat); end
    @(negedge clk);
    req_we[1] = 1'b0; req_addr[1] = 32'h10; req_be[1] = 4'h0;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
    n_checks++;
    if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL ws3_ready_before_accept got=%b exp=1", req_ready[1]); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    lat = 1;
    while (!rsp_valid[1] && lat < 20) begin
      n_checks++;
      if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL ws3_ready_in_wait got=%b exp=0", req_ready[1]); end
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL ws3_load_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid[1] !== 1'b1) begin n_fail++; $display("FAIL ws3_hold_valid cycle%0d got=%b exp=1", i, rsp_valid[1]); end
      n_checks++;
      if (rsp_rdata[1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ws3_hold_rdata cycle%0d got=%h exp=cafef00d", i, rsp_rdata[1]); end
      n_checks++;
      if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL ws3_hold_ready cycle%0d got=%b exp=0", i, req_ready[1]); end
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    $display("xact dut1 we=0 addr=00000010 held response released lat=%0d", lat);
    n_checks++;
    if (rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL ws3_post_hs_valid got=%b exp=0", rsp_valid[1]); end
    n_checks++;
    if (rsp_rdata[1] !== 32'h0) begin n_fail++; $display("FAIL ws3_post_hs_rdata got=%h exp=00000000", rsp_rdata[1]); end
    n_checks++;
    if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL ws3_post_hs_ready got=%b exp=1", req_ready[1]); end
  endtask

  task automatic test_addr_boundary();
    logic [31:0] rd; logic er; int lat;
    run_req(0, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat);
`ifdef DMEM_ERR_CHECK_EN
    run_req(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned_err got=%b exp=1", er); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL err_misaligned_rdata got=%h exp=00000000", rd); end
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL err_misaligned_latency got=%0d exp=1", lat); end
    run_req(0, 1'b1, BASE + DEPTH * 4, 32'h55, 4'hF, rd, er, lat);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_range_err got=%b exp=1", er); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL err_range_rdata got=%h exp=00000000", rd); end
    run_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL err_word0_intact got=%h exp=12345678", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL err_word0_err got=%b exp=0", er); end
`else
    run_req(0, 1'b1, BASE + DEPTH * 4, 32'h77, 4'hF, rd, er, lat);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL wrap_store_err got=%b exp=0", er); end
    run_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h77) begin n_fail++; $display("FAIL wrap_load_rdata got=%h exp=00000077", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL wrap_load_err got=%b exp=0", er); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    run_req(1, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, rd, er, lat);
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[1] = 32'h30; req_wdata[1] = 32'h99; req_be[1] = 4'hF;
    req_valid[1] = 1'b1;
    n_checks++;
    if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_before got=%b exp=1", req_ready[1]); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    srst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready_in_reset cycle%0d got=%b exp=0", i, req_ready[1]); end
      n_checks++;
      if (rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid_in_reset cycle%0d got=%b exp=0", i, rsp_valid[1]); end
    end
    srst[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_after got=%b exp=1", req_ready[1]); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rsp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp cycle%0d got=%b exp=0", i, rsp_valid[1]); end
      @(negedge clk);
    end
    run_req(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rst_mid_old_data got=%h exp=0badf00d", rd); end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL rst_mid_load_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_wait_states();
    test_addr_boundary();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
